step_phase_decoder: RTL and testbench

STEP_PHASE_DECODER -- requirements
Module: step_phase_decoder

---
 rtl/step_phase_decoder.sv | 122 ++++++++++++
 tb/tb_step_phase_decoder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_phase_decoder.sv
// Full-step stepper coil monitor: synchronises the coil drive pattern, debounces it and
// decodes accepted phase changes into step/direction/position with skip and illegal flags.
module step_phase_decoder #(
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned POS_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       coil,
    input  logic             clr_pos,
    output logic             locked,
    output logic [1:0]       phase,
    output logic             step_pulse,
    output logic             dir,
    output logic [POS_W-1:0] position,
    output logic             err_skip,
    output logic             err_illegal
);

    typedef enum logic [0:0] {StUnlocked, StLocked} state_e;

    localparam logic [8:0] AcceptCnt = 9'(STABLE_CNT);

    state_e     state;
    logic [3:0] sync_meta;
    logic [3:0] sync_out;
    logic [8:0] stable_cnt;
    logic       accept;
    logic       legal;
    logic [1:0] new_phase;
    logic [1:0] delta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 4'b0000;
            sync_out  <= 4'b0000;
        end else begin
            sync_meta <= coil;
            sync_out  <= sync_meta;
        end
    end

    // The count restarts on the edge that loads a new value into sync_out and saturates one
    // past the threshold, so each stable value is accepted exactly once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_cnt <= 9'd0;
        end else if (sync_out != sync_meta) begin
            stable_cnt <= 9'd1;
        end else if (stable_cnt != 9'd0 && stable_cnt <= AcceptCnt) begin
            stable_cnt <= stable_cnt + 9'd1;
        end
    end

    assign accept = (stable_cnt == AcceptCnt);

    always_comb begin
        legal     = 1'b1;
        new_phase = 2'd0;
        case (sync_out)
            4'b0101: new_phase = 2'd0;
            4'b0110: new_phase = 2'd1;
            4'b1010: new_phase = 2'd2;
            4'b1001: new_phase = 2'd3;
            default: legal = 1'b0;
        endcase
    end

    assign delta = new_phase - phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StUnlocked;
            phase       <= 2'd0;
            dir         <= 1'b1;
            position    <= '0;
            step_pulse  <= 1'b0;
            err_skip    <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            step_pulse  <= 1'b0;
            err_skip    <= 1'b0;
            err_illegal <= 1'b0;
            if (accept) begin
                if (!legal) begin
                    err_illegal <= 1'b1;
                    state       <= StUnlocked;
                end else if (state == StUnlocked) begin
                    phase <= new_phase;
                    state <= StLocked;
                end else begin
                    case (delta)
                        2'd1: begin
                            step_pulse <= 1'b1;
                            dir        <= 1'b1;
                            phase      <= new_phase;
                            position   <= position + POS_W'(1);
                        end
                        2'd3: begin
                            step_pulse <= 1'b1;
                            dir        <= 1'b0;
                            phase      <= new_phase;
                            position   <= position - POS_W'(1);
                        end
                        2'd2: begin
                            err_skip <= 1'b1;
                            phase    <= new_phase;
                        end
                        default: ;
                    endcase
                end
            end
            // Clear takes priority over a step landing on the same edge.
            if (clr_pos) begin
                position <= '0;
            end
        end
    end

    assign locked = (state == StLocked);

endmodule

// File: tb/tb_step_phase_decoder.sv
// Scoreboard bench: coil segments are generated with hold lengths, a pattern-level model
// predicts each accepted event and its cycle, and a monitor compares DUT strobes against it.
module tb_step_phase_decoder;

    localparam int unsigned STABLE = 4;
    localparam int unsigned PW     = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    coil;
    logic          clr_pos;
    logic          locked;
    logic [1:0]    phase;
    logic          step_pulse;
    logic          dir;
    logic [PW-1:0] position;
    logic          err_skip;
    logic          err_illegal;

    step_phase_decoder #(.STABLE_CNT(STABLE), .POS_W(PW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .coil        (coil),
        .clr_pos     (clr_pos),
        .locked      (locked),
        .phase       (phase),
        .step_pulse  (step_pulse),
        .dir         (dir),
        .position    (position),
        .err_skip    (err_skip),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    // Event kinds: 1 lock acquired, 2 step, 3 skip, 4 illegal
    typedef struct {
        int t;
        int kind;
        int ph;
        int dr;
        int pos;
        int lk;
    } exp_t;

    exp_t q[$];
    bit   clr_sched[int];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   prev_locked = 0;

    // Reference state
    int               m_locked;
    int               m_phase;
    int               m_dir;
    logic signed [PW-1:0] m_pos;
    logic [3:0]       last_val;

    logic [3:0] legal_tab [4] = '{4'b0101, 4'b0110, 4'b1010, 4'b1001};

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        clr_pos = clr_sched.exists(cyc);
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int decode(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (legal_tab[i] == v) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_locked = 0;
        m_phase  = 0;
        m_dir    = 1;
        m_pos    = '0;
        last_val = 4'b0000;
    endtask

    // A value held for len sampling edges starting after cycle start is accepted iff
    // len >= STABLE, and its effect is visible after edge start+STABLE+2.
    task automatic model_seg(input logic [3:0] v, input int start, input int len,
                             input bit force_clr);
        exp_t e;
        int   p;
        int   d;
        bit   clr;
        if (len < STABLE) return;
        e.t  = start + STABLE + 2;
        clr  = force_clr || ($urandom_range(0, 5) == 0);
        if (clr) clr_sched[e.t - 1] = 1'b1;
        p      = decode(v);
        e.kind = 0;
        if (p < 0) begin
            e.kind   = 4;
            m_locked = 0;
        end else if (m_locked == 0) begin
            e.kind   = 1;
            m_locked = 1;
            m_phase  = p;
        end else begin
            d = (p - m_phase + 4) % 4;
            if (d == 1) begin
                e.kind = 2; m_dir = 1; m_pos = m_pos + 1; m_phase = p;
            end else if (d == 3) begin
                e.kind = 2; m_dir = 0; m_pos = m_pos - 1; m_phase = p;
            end else if (d == 2) begin
                e.kind = 3; m_phase = p;
            end
        end
        if (clr) m_pos = '0;
        e.ph  = m_phase;
        e.dr  = m_dir;
        e.pos = int'(m_pos);
        e.lk  = m_locked;
        if (e.kind != 0) q.push_back(e);
    endtask

    task automatic drive_seg(input logic [3:0] v, input int len, input bit force_clr);
        @(posedge clk);
        #1;
        coil = v;
        model_seg(v, cyc, len, force_clr);
        last_val = v;
        repeat (len - 1) @(posedge clk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        chk("queue_drained", q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   nstrobe;
        int   akind;
        if (!rst_n) begin
            prev_locked = 0;
        end else begin
            nstrobe = int'(step_pulse) + int'(err_skip) + int'(err_illegal);
            akind = step_pulse ? 2 : err_skip ? 3 : err_illegal ? 4 :
                    (int'(locked) != prev_locked) ? 1 : 0;
            if (nstrobe > 1) begin
                checks++;
                failures++;
                $display("FAIL strobe_overlap: got %0d strobes at cycle %0d expected 1",
                         nstrobe, cyc);
            end
            if (akind != 0) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none",
                             akind, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.t != cyc || e.kind != akind || e.ph != int'(phase) ||
                        e.dr != int'(dir) || e.pos != int'($signed(position)) ||
                        e.lk != int'(locked)) begin
                        failures++;
                        $display({"FAIL event: got cyc=%0d kind=%0d phase=%0d dir=%0d pos=%0d ",
                                  "locked=%0d expected cyc=%0d kind=%0d phase=%0d dir=%0d ",
                                  "pos=%0d locked=%0d"},
                                 cyc, akind, phase, dir, $signed(position), locked,
                                 e.t, e.kind, e.ph, e.dr, e.pos, e.lk);
                    end
                end
            end
            prev_locked = int'(locked);
        end
    end

    task automatic reset_midcount();
        logic [3:0] v;
        v = legal_tab[(decode(last_val) + 1 + $urandom_range(0, 2)) % 4];
        @(posedge clk);
        #1;
        coil = v;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_locked", int'(locked), 0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_dir", int'(dir), 1);
        chk("rst_position", int'(position), 0);
        chk("rst_strobes", int'({step_pulse, err_skip, err_illegal}), 0);
        #2;
        rst_n = 1'b1;
        prev_locked = 0;
        model_reset();
        // coil is still held, so re-acquisition counts from the first edge after release
        model_seg(v, cyc, 12, 1'b0);
        last_val = v;
        repeat (12) @(posedge clk);
        wait_drain();
    endtask

    task automatic random_segs(input int n);
        logic [3:0] v;
        int         len;
        for (int i = 0; i < n; i++) begin
            do begin
                if ($urandom_range(0, 9) < 8) v = legal_tab[$urandom_range(0, 3)];
                else v = 4'($urandom);
            end while (v == last_val);
            len = $urandom_range(1, 8);
            drive_seg(v, len, 1'b0);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        coil    = 4'b0000;
        clr_pos = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_locked", int'(locked), 0);
        chk("reset_dir", int'(dir), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Lock, then 8 forward steps wrapping 7 -> -8, then a step with a coincident clear
        drive_seg(4'b0101, 8, 1'b0);
        drive_seg(4'b0110, 6, 1'b0);
        drive_seg(4'b1010, 6, 1'b0);
        drive_seg(4'b1001, 6, 1'b0);
        drive_seg(4'b0101, 6, 1'b0);
        drive_seg(4'b0110, 6, 1'b0);
        drive_seg(4'b1010, 6, 1'b0);
        drive_seg(4'b1001, 6, 1'b0);
        drive_seg(4'b0101, 6, 1'b0);
        drive_seg(4'b0110, 6, 1'b1);
        // Reverse steps, a short glitch that must be ignored, then a long one
        drive_seg(4'b0101, 6, 1'b0);
        drive_seg(4'b1001, 6, 1'b0);
        drive_seg(4'b1010, 6, 1'b0);
        drive_seg(4'b0110, 3, 1'b0);
        drive_seg(4'b1010, 6, 1'b0);
        drive_seg(4'b0110, 5, 1'b0);
        drive_seg(4'b0101, 6, 1'b0);
        // Skip by two, then an all-off illegal pattern, then relock
        drive_seg(4'b1010, 6, 1'b0);
        drive_seg(4'b0000, 6, 1'b0);
        drive_seg(4'b0101, 12, 1'b0);
        wait_drain();

        random_segs(150);
        drive_seg((last_val == 4'b1001) ? 4'b0101 : 4'b1001, 12, 1'b0);
        wait_drain();

        reset_midcount();
        random_segs(100);
        drive_seg((last_val == 4'b0110) ? 4'b1010 : 4'b0110, 12, 1'b0);
        wait_drain();
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
